// File: rtl/wm_pkg.sv
// Shared types and constants for the wooden-man referee: state codes, LFSR
// constants and the green-length helper.
package wm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_COUNT  = 4'd1,
    ST_GREEN  = 4'd2,
    ST_TURN_R = 4'd3,
    ST_RED    = 4'd4,
    ST_TURN_G = 4'd5,
    ST_DONE   = 4'd6
  } wm_state_e;

  localparam int unsigned TMR_W  = 16;
  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [TMR_W-1:0] green_len(input logic [TMR_W-1:0] base,
                                                 input logic [5:0]       rnd);
    return base + TMR_W'(rnd);
  endfunction

endpackage

// File: rtl/wm_tick_timer.sv
// Game-tick prescaler plus down-counter; done_c pulses in the last cycle of a
// loaded duration, so a load of D ticks spans exactly D*TICK_DIV cycles.
module wm_tick_timer #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;

  assign tick_c = (pre_q == PRE_MAX);
  assign done_c = tick_c && (cnt_q == CNT_W'(1));

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      pre_d = '0;
      cnt_d = load_val;
    end else if (clear) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick_c) begin
      pre_d = '0;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wooden_man_referee.sv
// N-player "1-2-3 wooden man" referee: light cycle, doll turn, positions,
// eliminations and winners. Define WM_RANDOM_GREEN_EN for randomised green length.
module wooden_man_referee
  import wm_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned POS_W       = 5,
  parameter int unsigned GOAL        = 20,
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned COUNT_TICKS = 300,
  parameter int unsigned GREEN_BASE  = 200,
  parameter int unsigned TURN_TICKS  = 50,
  parameter int unsigned RED_TICKS   = 300
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_PLAYERS-1:0]         move,
  output logic [N_PLAYERS*POS_W-1:0]   pos,
  output logic [N_PLAYERS-1:0]         alive,
  output logic [N_PLAYERS-1:0]         finished,
  output logic                         allow,
  output logic                         turn,
  output logic                         music_on,
  output logic                         game_over,
  output logic [3:0]                   now_state
);

  localparam logic [POS_W-1:0] GOAL_V  = POS_W'(GOAL);
  localparam logic [POS_W-1:0] GOAL_M1 = POS_W'(GOAL - 1);

  wm_state_e state_q, state_d;

  logic [N_PLAYERS*POS_W-1:0] pos_q, pos_d;
  logic [N_PLAYERS-1:0]       alive_q, alive_d;
  logic [N_PLAYERS-1:0]       finished_q, finished_d;

  logic       allow_q, allow_d;
  logic       turn_q, turn_d;
  logic       music_q, music_d;
  logic       over_q, over_d;
  logic [3:0] code_q, code_d;

  logic             tmr_load_c;
  logic             tmr_clear_c;
  logic             tmr_done_c;
  logic [TMR_W-1:0] tmr_val_c;
  logic [TMR_W-1:0] green_ticks_c;
  logic [5:0]       green_rnd_c;
  logic             active_c;
  logic             all_out_c;
  logic             new_game_c;

`ifdef WM_RANDOM_GREEN_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign green_rnd_c = lfsr_q[5:0];
`else
  assign green_rnd_c = 6'd0;
`endif

  assign green_ticks_c = green_len(TMR_W'(GREEN_BASE), green_rnd_c);

  assign active_c    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign all_out_c   = &(finished_q | ~alive_q);
  assign new_game_c  = !active_c && (state_d == ST_COUNT);
  assign tmr_clear_c = !active_c;

  wm_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .clear    (tmr_clear_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  // Light-cycle sequencing; game end overrides any timer transition
  always_comb begin
    state_d    = state_q;
    tmr_val_c  = '0;
    tmr_load_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: if (start)      state_d = ST_COUNT;
      ST_COUNT:         if (tmr_done_c) state_d = ST_GREEN;
      ST_GREEN:         if (tmr_done_c) state_d = ST_TURN_R;
      ST_TURN_R:        if (tmr_done_c) state_d = ST_RED;
      ST_RED:           if (tmr_done_c) state_d = ST_TURN_G;
      ST_TURN_G:        if (tmr_done_c) state_d = ST_GREEN;
      default:                          state_d = ST_IDLE;
    endcase

    if (active_c && all_out_c) state_d = ST_DONE;

    case (state_d)
      ST_COUNT:            tmr_val_c = TMR_W'(COUNT_TICKS);
      ST_GREEN:            tmr_val_c = green_ticks_c;
      ST_TURN_R, ST_TURN_G: tmr_val_c = TMR_W'(TURN_TICKS);
      ST_RED:              tmr_val_c = TMR_W'(RED_TICKS);
      default:             tmr_val_c = '0;
    endcase

    tmr_load_c = (state_d != state_q);

    allow_d = (state_q == ST_GREEN);
    music_d = (state_q == ST_GREEN);
    turn_d  = (state_q == ST_TURN_R) || (state_q == ST_RED) || (state_q == ST_TURN_G);
    over_d  = (state_q == ST_DONE);
    code_d  = state_q;
  end

  // Per-player step / elimination, judged against the registered state
  always_comb begin
    pos_d      = pos_q;
    alive_d    = alive_q;
    finished_d = finished_q;

    if (new_game_c) begin
      pos_d      = '0;
      alive_d    = '1;
      finished_d = '0;
    end else begin
      for (int i = 0; i < int'(N_PLAYERS); i++) begin
        if (move[i] && alive_q[i] && !finished_q[i]) begin
          if (state_q == ST_GREEN && pos_q[i*POS_W +: POS_W] < GOAL_V) begin
            pos_d[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] + POS_W'(1);
            if (pos_q[i*POS_W +: POS_W] == GOAL_M1) finished_d[i] = 1'b1;
          end else if (state_q == ST_RED) begin
            alive_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      alive_q    <= '1;
      finished_q <= '0;
      allow_q    <= 1'b0;
      turn_q     <= 1'b0;
      music_q    <= 1'b0;
      over_q     <= 1'b0;
      code_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      alive_q    <= alive_d;
      finished_q <= finished_d;
      allow_q    <= allow_d;
      turn_q     <= turn_d;
      music_q    <= music_d;
      over_q     <= over_d;
      code_q     <= code_d;
    end
  end

  assign pos       = pos_q;
  assign alive     = alive_q;
  assign finished  = finished_q;
  assign allow     = allow_q;
  assign turn      = turn_q;
  assign music_on  = music_q;
  assign game_over = over_q;
  assign now_state = code_q;

endmodule

// File: tb/tb_wooden_man_referee.sv
// Directed bench for wooden_man_referee with a small timing configuration
// (2 players, GOAL=3, TICK_DIV=4, COUNT=3, GREEN=5, TURN=2, RED=6 ticks).
module tb_wooden_man_referee;

  localparam int unsigned NP = 2;
  localparam int unsigned PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NP-1:0] move;
  logic [NP*PW-1:0] pos;
  logic [NP-1:0] alive;
  logic [NP-1:0] finished;
  logic          allow, turn, music_on, game_over;
  logic [3:0]    now_state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wooden_man_referee #(
    .N_PLAYERS   (NP),
    .POS_W       (PW),
    .GOAL        (3),
    .TICK_DIV    (4),
    .COUNT_TICKS (3),
    .GREEN_BASE  (5),
    .TURN_TICKS  (2),
    .RED_TICKS   (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .move      (move),
    .pos       (pos),
    .alive     (alive),
    .finished  (finished),
    .allow     (allow),
    .turn      (turn),
    .music_on  (music_on),
    .game_over (game_over),
    .now_state (now_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_code(input logic [3:0] code, input int budget);
    int k = 0;
    while (now_state !== code && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (now_state !== code) begin
      $display("FAIL wait_state_%0d: now_state=%0d required %0d within %0d cycles",
               code, now_state, code, budget);
      n_bad++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    if (now_state !== 4'd0) begin
      $display("FAIL %s_state: got %0d want 0", tag, now_state); n_bad++;
    end
    n_vec++;
    if (pos !== '0) begin
      $display("FAIL %s_pos: got %0h want 0", tag, pos); n_bad++;
    end
    n_vec++;
    if (alive !== 2'b11 || finished !== 2'b00) begin
      $display("FAIL %s_flags: alive=%b finished=%b want 11/00", tag, alive, finished); n_bad++;
    end
    n_vec++;
    if ({allow, turn, music_on, game_over} !== 4'b0000) begin
      $display("FAIL %s_lights: allow/turn/music/over=%b want 0000", tag,
               {allow, turn, music_on, game_over}); n_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; move = '0;
    #1 rst = 1'b0;
    #1;
    check_reset_values("reset");
    step(); step();
    rst = 1'b1;
    step();
    n_vec++;
    if (now_state !== 4'd0) begin
      $display("FAIL idle_hold: got %0d want 0", now_state); n_bad++;
    end
  endtask

  task automatic test_countdown();
    int c = 0;
    start = 1'b1; step(); start = 1'b0;
    wait_code(4'd1, 4);
    while (now_state === 4'd1 && c < 40) begin
      c++;
      step();
    end
    n_vec++;
    if (c != 12) begin
      $display("FAIL count_len: got %0d cycles want 12", c); n_bad++;
    end
    n_vec++;
    if (now_state !== 4'd2 || allow !== 1'b1 || music_on !== 1'b1 || turn !== 1'b0) begin
      $display("FAIL green_entry: state=%0d allow=%b music=%b turn=%b want 2/1/1/0",
               now_state, allow, music_on, turn); n_bad++;
    end
  endtask

  // p0 steps 4 times (last one past GOAL); p1 steps in the expiry cycle and first TURN_R cycle
  task automatic test_green_moves();
    int g = 0;
    while (now_state === 4'd2 && g < 60) begin
      g++;
      if (g == 4) begin
        n_vec++;
        if (pos[4:0] !== 5'd3 || finished !== 2'b01) begin
          $display("FAIL p0_goal: pos0=%0d finished=%b want 3/01", pos[4:0], finished); n_bad++;
        end
      end
      move = {(g == 19 || g == 20), (g <= 4)};
      step();
      move = '0;
    end
    n_vec++;
    if (g != 20) begin
      $display("FAIL green_len: got %0d cycles want 20", g); n_bad++;
    end
    n_vec++;
    if (now_state !== 4'd3 || turn !== 1'b1 || allow !== 1'b0 || music_on !== 1'b0) begin
      $display("FAIL turn_r_entry: state=%0d turn=%b allow=%b music=%b want 3/1/0/0",
               now_state, turn, allow, music_on); n_bad++;
    end
    n_vec++;
    if (pos[4:0] !== 5'd3) begin
      $display("FAIL p0_capped: got %0d want 3", pos[4:0]); n_bad++;
    end
    n_vec++;
    if (pos[9:5] !== 5'd1 || alive !== 2'b11) begin
      $display("FAIL p1_expiry_turn: pos1=%0d alive=%b want 1/11", pos[9:5], alive); n_bad++;
    end
  endtask

  task automatic test_red();
    wait_code(4'd4, 20);
    start = 1'b1; step(); start = 1'b0;
    step();
    n_vec++;
    if (now_state !== 4'd4 || pos[4:0] !== 5'd3) begin
      $display("FAIL start_in_red: state=%0d pos0=%0d want 4/3", now_state, pos[4:0]); n_bad++;
    end
    move = 2'b10; step(); move = '0;
    n_vec++;
    if (alive !== 2'b01 || pos[9:5] !== 5'd1 || game_over !== 1'b0) begin
      $display("FAIL p1_red: alive=%b pos1=%0d over=%b want 01/1/0", alive, pos[9:5], game_over);
      n_bad++;
    end
    step(); step();
    n_vec++;
    if (now_state !== 4'd6 || game_over !== 1'b1 || turn !== 1'b0) begin
      $display("FAIL done_entry: state=%0d over=%b turn=%b want 6/1/0", now_state, game_over, turn);
      n_bad++;
    end
    n_vec++;
    if (finished !== 2'b01 || alive !== 2'b01) begin
      $display("FAIL winners: finished=%b alive=%b want 01/01", finished, alive); n_bad++;
    end
  endtask

  task automatic test_restart();
    start = 1'b1; step(); start = 1'b0;
    n_vec++;
    if (pos !== '0 || alive !== 2'b11 || finished !== 2'b00) begin
      $display("FAIL restart_clear: pos=%0h alive=%b finished=%b want 0/11/00", pos, alive, finished);
      n_bad++;
    end
    step();
    n_vec++;
    if (now_state !== 4'd1 || game_over !== 1'b0) begin
      $display("FAIL restart_count: state=%0d over=%b want 1/0", now_state, game_over); n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    wait_code(4'd2, 20);
    while (now_state === 4'd2 && g < 60) begin
      g++;
      move = (g == 19) ? 2'b11 : 2'b00;
      step();
      move = '0;
    end
    n_vec++;
    if (pos[4:0] !== 5'd1 || pos[9:5] !== 5'd1) begin
      $display("FAIL both_expiry: pos0=%0d pos1=%0d want 1/1", pos[4:0], pos[9:5]); n_bad++;
    end
    n_vec++;
    if (now_state !== 4'd3 || g != 20) begin
      $display("FAIL both_expiry_state: state=%0d green=%0d want 3/20", now_state, g); n_bad++;
    end
  endtask

  task automatic test_async_reset();
    wait_code(4'd4, 20);
    #1 rst = 1'b0;
    #1;
    check_reset_values("async");
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_green_moves();
    test_red();
    test_restart();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wooden_man_referee.md
Name: wooden_man_referee

Overview:
- Parametrised N-player referee for the "1-2-3 wooden man" game; successor to the fixed two-player control path.
- Runs the green/red light cycle and time-bases the doll turn.
- Accepts per-player step pulses (from keyboard decode), tracks positions, eliminates players that move on red, and declares winners.
- Drives the motor turn, music enable and seven-segment state code.

Parameters:
- N_PLAYERS, 2, number of players (1..8).
- POS_W, 5, position width per player.
- GOAL, 20, finishing position (must be < 2**POS_W).
- TICK_DIV, 1000000, clk cycles per game tick (10 ms at 100 MHz).
- COUNT_TICKS, 300, countdown length before the first green.
- GREEN_BASE, 200, minimum green length in ticks.
- TURN_TICKS, 50, doll turning time in ticks, both directions.
- RED_TICKS, 300, red length in ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; starts or restarts a game
- move  in  N_PLAYERS  single-cycle step pulse per player
- pos  out  N_PLAYERS*POS_W  packed positions; player i at [i*POS_W +: POS_W]
- alive  out  N_PLAYERS  1 = not eliminated
- finished  out  N_PLAYERS  1 = reached GOAL
- allow  out  1  1 only in GREEN
- turn  out  1  1 = doll faces players; high in TURN_R, RED and TURN_G
- music_on  out  1  1 in GREEN
- game_over  out  1  1 in DONE
- now_state  out  4  state code for display

Behaviour:
- Reset values:
  - State IDLE; pos all 0; alive all 1; finished all 0.
  - allow = turn = music_on = game_over = 0; now_state = 0.
  - Prescaler and timer cleared; LFSR = 16'hACE1.
- State codes: IDLE=0, COUNT=1, GREEN=2, TURN_R=3, RED=4, TURN_G=5, DONE=6.
- Tick: the prescaler counts 0..TICK_DIV-1 and emits a tick on TICK_DIV-1. It is cleared on every state entry, so a state of D ticks lasts exactly D*TICK_DIV cycles.
- Transitions:
  - IDLE -> COUNT on start. Entering COUNT resets pos=0, alive=all 1, finished=0.
  - COUNT -> GREEN after COUNT_TICKS.
  - GREEN -> TURN_R after green length.
  - TURN_R -> RED after TURN_TICKS.
  - RED -> TURN_G after RED_TICKS.
  - TURN_G -> GREEN after TURN_TICKS.
  - Any active state -> DONE in the cycle after every player is finished or eliminated (checked on registered flags). This has priority over timer transitions.
  - DONE -> COUNT on start.
  - start is ignored in COUNT through TURN_G.
- Moves are evaluated against the registered state of the same cycle; all players are handled in parallel, one step max per cycle.
  - GREEN: for a player with alive & ~finished, pos += 1. If the new pos == GOAL, set finished. pos never exceeds GOAL.
  - RED: a player with alive & ~finished has alive cleared; pos is held.
  - COUNT, TURN_R, TURN_G, IDLE, DONE: moves are ignored.
  - Finished or eliminated players: moves are ignored.
- A move in the last GREEN cycle (the timer-expiry cycle) counts as a legal step.
- A move in the first TURN_R cycle is ignored, not penalised.
- Outputs are registered; each changes one cycle after the state register.
- Green length:
  - Base: GREEN_BASE ticks.
  - With the feature enabled (see Optional Feature): GREEN_BASE + lfsr[5:0] ticks, sampled on GREEN entry.
  - The LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every cycle.
- Reset asserted mid-game returns to the reset values immediately, asynchronously.
- A player that is both at GOAL and alive is a winner; the winners are exactly the finished bits in DONE.

Optional Feature:
- Macro: WM_RANDOM_GREEN_EN.
- Defined: green length is randomised as above, so players cannot predict the turn.
- Undefined: green length is fixed at GREEN_BASE; the LFSR is not instantiated.

Decomposition:
- Shared package wm_pkg holds:
  - the state enum with the fixed codes above;
  - the LFSR seed and tap constants;
  - a function that computes green length.
- One sub-module, wm_tick_timer: prescaler plus down-counter with load/clear inputs and a done pulse. It is reused for all timed states.

Test Plan:
All scenarios use N_PLAYERS=2, GOAL=3, TICK_DIV=4, COUNT_TICKS=3, GREEN_BASE=5, TURN_TICKS=2, RED_TICKS=6, feature undefined.
- Reset then start -> now_state=1 for exactly 12 cycles, then 2 with allow=1, music_on=1. GREEN lasts 20 cycles, then 3 with turn=1.
- Three p0 move pulses in GREEN -> pos[4:0]=3, finished=01. A 4th pulse leaves pos at 3.
- A p1 pulse in RED -> alive=01 and pos1 held. A p1 pulse in TURN_R -> no change.
- p0 finishes and p1 is eliminated -> DONE (now_state=6, game_over=1) one cycle later; finished=01.
- Simultaneous p0 and p1 pulses in the GREEN expiry cycle -> both positions +1; state goes to TURN_R.
- start pulse during RED -> ignored. start in DONE -> COUNT with pos=0, alive=11. rst low mid-RED -> all outputs at reset values without a clock edge.
